// File: rtl/modulo_contador_sync_param_updown_pkg.sv
// Shared definitions for the parametrised up/down modulo counter:
// direction encodings and the parameter-legality helper.
package modulo_contador_sync_param_updown_pkg;

  localparam logic CONT_UP   = 1'b1;
  localparam logic CONT_DOWN = 1'b0;

  // True when WIDTH/MODULO/RESET_VALUE describe a reachable, legal count sequence.
  function automatic bit params_ok(input int width, input int modulo, input int reset_value);
    longint mod_l;
    longint lim_l;
    mod_l = longint'(modulo);
    lim_l = longint'(1) << width;
    return (width >= 1) && (mod_l >= 2) && (mod_l <= lim_l) &&
           (reset_value >= 0) && (longint'(reset_value) < mod_l);
  endfunction

endpackage

// File: rtl/modulo_contador_sync_param_updown_prox_estado.sv
// Combinational next-state for the modulo counter: load saturation, up/down
// step with wrap, terminal-count and wrap detection. Zero latency, no state.
module modulo_contador_sync_param_updown_prox_estado
  import modulo_contador_sync_param_updown_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_enable,
  input  logic             i_up_down,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_wrap,
  output logic             o_terminal
);

  // One extra bit so MODULO == 2**WIDTH is representable in the range compares.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULO - 1);

  logic w_q_valid;
  logic w_load_valid;
  logic w_at_max;
  logic w_at_zero;

  assign w_q_valid    = {1'b0, i_q} < MOD_EXT;
  assign w_load_valid = {1'b0, i_load_value} < MOD_EXT;
  assign w_at_max     = (i_q == Q_MAX);
  assign w_at_zero    = (i_q == '0);

  assign o_terminal = i_enable & ((i_up_down == CONT_DOWN) ? w_at_zero : w_at_max);

  always_comb begin
    o_q_next = i_q;
    o_wrap   = 1'b0;
    if (i_load) begin
      o_q_next = w_load_valid ? i_load_value : Q_MAX;
    end else if (i_enable) begin
      if (!w_q_valid) begin
        // Recovery from an out-of-range state: restart the sequence at zero.
        o_q_next = '0;
      end else if (i_up_down == CONT_UP) begin
        if (w_at_max) begin
          o_q_next = '0;
          o_wrap   = 1'b1;
        end else begin
          o_q_next = i_q + 1'b1;
        end
      end else begin
        if (w_at_zero) begin
          o_q_next = Q_MAX;
          o_wrap   = 1'b1;
        end else begin
          o_q_next = i_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modulo_contador_sync_param_updown.sv
// Parametrised synchronous up/down modulo counter with parallel load and cascade
// terminal count; q and wrap_pulse are registered, terminal is combinational.
module modulo_contador_sync_param_updown
  import modulo_contador_sync_param_updown_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULO      = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_up_down,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_q,
  output logic             o_terminal,
  output logic             o_wrap_pulse
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

  generate
    if (!params_ok(WIDTH, MODULO, RESET_VALUE)) begin : g_bad_params
      $error("modulo_contador_sync_param_updown: illegal WIDTH/MODULO/RESET_VALUE");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_wrap_pulse;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap;

  modulo_contador_sync_param_updown_prox_estado #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_prox_estado (
    .i_q          (r_q),
    .i_enable     (i_enable),
    .i_up_down    (i_up_down),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .o_q_next     (w_q_next),
    .o_wrap       (w_wrap),
    .o_terminal   (o_terminal)
  );

  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_q          <= RST_Q;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_q          <= w_q_next;
      r_wrap_pulse <= w_wrap;
    end
  end

  assign o_q          = r_q;
  assign o_wrap_pulse = r_wrap_pulse;

endmodule

// File: tb/tb_modulo_contador_sync_param_updown.sv
// Directed bench: vector table on a MODULO=10 counter plus hand-written
// sequences for async clear, 2**WIDTH wrap, full up/down wraps and a cascade.
module tb_modulo_contador_sync_param_updown;

  logic clk;
  logic clear;

  logic       en16, ud16, ld16;
  logic [3:0] lv16, q16;
  logic       term16, wrap16;

  logic       en10, ud10, ld10;
  logic [3:0] lv10, q10;
  logic       term10, wrap10;

  logic       en_l;
  logic [3:0] q_l, q_m;
  logic       term_l, term_m, wrap_l, wrap_m;

  int checks;
  int failures;

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       ud;
    logic [3:0] q;
    logic       term;
    logic       wrap;
  } vec_t;

  vec_t vecs [20];

  modulo_contador_sync_param_updown #(.WIDTH(4), .MODULO(16), .RESET_VALUE(0)) u_dut16 (
    .i_clock(clk), .i_clear(clear), .i_enable(en16), .i_up_down(ud16),
    .i_load(ld16), .i_load_value(lv16), .o_q(q16), .o_terminal(term16),
    .o_wrap_pulse(wrap16)
  );

  modulo_contador_sync_param_updown #(.WIDTH(4), .MODULO(10), .RESET_VALUE(0)) u_dut10 (
    .i_clock(clk), .i_clear(clear), .i_enable(en10), .i_up_down(ud10),
    .i_load(ld10), .i_load_value(lv10), .o_q(q10), .o_terminal(term10),
    .o_wrap_pulse(wrap10)
  );

  modulo_contador_sync_param_updown #(.WIDTH(4), .MODULO(10), .RESET_VALUE(0)) u_lsb (
    .i_clock(clk), .i_clear(clear), .i_enable(en_l), .i_up_down(1'b1),
    .i_load(1'b0), .i_load_value(4'd0), .o_q(q_l), .o_terminal(term_l),
    .o_wrap_pulse(wrap_l)
  );

  modulo_contador_sync_param_updown #(.WIDTH(4), .MODULO(10), .RESET_VALUE(0)) u_msb (
    .i_clock(clk), .i_clear(clear), .i_enable(term_l), .i_up_down(1'b1),
    .i_load(1'b0), .i_load_value(4'd0), .o_q(q_m), .o_terminal(term_m),
    .o_wrap_pulse(wrap_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int wraps_m;
    int wraps_l;
    int exp_q;

    checks   = 0;
    failures = 0;

    // ld, lv, en, ud -> q, term, wrap (MODULO=10, starting from q=0)
    vecs[0]  = '{1'b1, 4'd5,  1'b1, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd12, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd2,  1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd9, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd8, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd8, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd8, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'd4,  1'b1, 1'b1, 4'd4, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd4, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 4'd9,  1'b0, 1'b1, 4'd9, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 4'd10, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'd15, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 4'd0,  1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd1, 1'b0, 1'b0};

    clear = 1'b0;
    en16 = 1'b0; ud16 = 1'b1; ld16 = 1'b0; lv16 = 4'd0;
    en10 = 1'b0; ud10 = 1'b1; ld10 = 1'b0; lv10 = 4'd0;
    en_l = 1'b0;

    #1;
    check("reset_q16", q16, 0);
    check("reset_wrap16", wrap16, 0);
    check("reset_q10", q10, 0);

    // Count DUT16 up to 9, then pull clear between edges.
    @(negedge clk);
    clear = 1'b1; en16 = 1'b1; ud16 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      check("count16_q", q16, i);
    end
    #1 clear = 1'b0;
    #1;
    check("async_clear_q", q16, 0);
    check("async_clear_wrap", wrap16, 0);
    @(posedge clk); #1;
    check("clear_held_edge_q", q16, 0);
    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1;
    check("clear_release_q", q16, 1);

    // Wrap at the full 2**WIDTH boundary.
    @(negedge clk) begin ld16 = 1'b1; lv16 = 4'd15; end
    @(posedge clk); #1;
    check("load15_q16", q16, 15);
    check("load15_term16", term16, 1);
    @(negedge clk) ld16 = 1'b0;
    @(posedge clk); #1;
    check("wrap16_q", q16, 0);
    check("wrap16_pulse", wrap16, 1);
    @(negedge clk) en16 = 1'b0;
    @(posedge clk); #1;
    check("wrap16_pulse_clear", wrap16, 0);

    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      ld10 = vecs[v].ld; lv10 = vecs[v].lv; en10 = vecs[v].en; ud10 = vecs[v].ud;
      @(posedge clk); #1;
      check($sformatf("vec%0d_q", v), q10, vecs[v].q);
      check($sformatf("vec%0d_term", v), term10, vecs[v].term);
      check($sformatf("vec%0d_wrap", v), wrap10, vecs[v].wrap);
    end

    // Full up sequence 0..9,0.
    @(negedge clk) begin ld10 = 1'b1; lv10 = 4'd0; en10 = 1'b0; end
    @(posedge clk);
    @(negedge clk) begin ld10 = 1'b0; en10 = 1'b1; ud10 = 1'b1; end
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      exp_q = i % 10;
      check("upseq_q", q10, exp_q);
      check("upseq_term", term10, (exp_q == 9) ? 1 : 0);
      check("upseq_wrap", wrap10, (i == 10) ? 1 : 0);
    end

    // Down sequence 2,1,0,9,8.
    @(negedge clk) begin ld10 = 1'b1; lv10 = 4'd2; en10 = 1'b0; end
    @(posedge clk); #1;
    check("downseq_start", q10, 2);
    @(negedge clk) begin ld10 = 1'b0; en10 = 1'b1; ud10 = 1'b0; end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      exp_q = (12 - i) % 10;
      check("downseq_q", q10, exp_q);
      check("downseq_term", term10, (exp_q == 0) ? 1 : 0);
      check("downseq_wrap", wrap10, (exp_q == 9) ? 1 : 0);
    end
    @(negedge clk) en10 = 1'b0;

    // Two-stage decimal cascade over 100 enabled cycles.
    @(negedge clk);
    clear = 1'b0;
    #1 clear = 1'b1;
    en_l = 1'b1;
    wraps_m = 0;
    wraps_l = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (wrap_m) wraps_m++;
      if (wrap_l) wraps_l++;
      if (c == 37) begin
        check("cascade37_lsb", q_l, 7);
        check("cascade37_msb", q_m, 3);
      end
    end
    check("cascade_lsb_q", q_l, 0);
    check("cascade_msb_q", q_m, 0);
    check("cascade_msb_wrap_now", wrap_m, 1);
    check("cascade_msb_wrap_count", wraps_m, 1);
    check("cascade_lsb_wrap_count", wraps_l, 10);
    @(negedge clk) en_l = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
